// File: rtl/video_line_scaler.sv
// video_line_scaler: ring of NUM_LINES line buffers sitting between the NES
// pixel FIFO and the VGA timing generator. Source lines are replayed with
// 2^SCALE_X_LOG2 horizontal and SCALE_Y vertical replication.
// Optional build macro: VIDEO_LINE_SCALER_BORDER_EN (fills VIS..VGA_ACTIVE_WIDTH-1
// with BORDER_RGB instead of black).
module video_line_scaler #(
  parameter int                          PIXEL_BITWIDTH   = 11,
  parameter int                          RGB_BITWIDTH     = 8,
  parameter int                          SRC_WIDTH        = 256,
  parameter int                          NUM_LINES        = 3,
  parameter int                          SCALE_X_LOG2     = 1,
  parameter int                          SCALE_Y          = 2,
  parameter int                          VGA_ACTIVE_WIDTH = 640,
  parameter logic [3*RGB_BITWIDTH-1:0]   BORDER_RGB       = '0
) (
  input  logic                               i_clk,
  input  logic                               i_reset,
  input  logic                               i_pixel_valid,
  input  logic [3*RGB_BITWIDTH-1:0]          i_pixel_rgb,
  output logic                               o_pixel_ready,
  output logic                               o_vga_enable,
  input  logic [PIXEL_BITWIDTH-1:0]          i_vga_x,
  output logic [RGB_BITWIDTH-1:0]            o_vga_red,
  output logic [RGB_BITWIDTH-1:0]            o_vga_green,
  output logic [RGB_BITWIDTH-1:0]            o_vga_blue,
  output logic                               o_underflow,
  output logic [$clog2(NUM_LINES+1)-1:0]     o_lines_buffered
);

  localparam int PW     = 3 * RGB_BITWIDTH;
  localparam int FILL_W = $clog2(NUM_LINES + 1);
  localparam int PTR_W  = $clog2(NUM_LINES);
  localparam int IDX_W  = $clog2(SRC_WIDTH);
  localparam int REP_W  = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;
  localparam int VIS    = SRC_WIDTH << SCALE_X_LOG2;

  localparam logic [PIXEL_BITWIDTH-1:0] VIS_X     = PIXEL_BITWIDTH'(VIS);
  localparam logic [PTR_W-1:0]          PTR_LAST  = PTR_W'(NUM_LINES - 1);
  localparam logic [IDX_W-1:0]          IDX_LAST  = IDX_W'(SRC_WIDTH - 1);
  localparam logic [REP_W-1:0]          REP_LAST  = REP_W'(SCALE_Y - 1);
  localparam logic [FILL_W-1:0]         FILL_MAX  = FILL_W'(NUM_LINES);
  localparam logic [FILL_W-1:0]         FILL_TWO  = FILL_W'(2);

  logic [PW-1:0]       line_mem [NUM_LINES][SRC_WIDTH];

  logic [PTR_W-1:0]    wptr;
  logic [PTR_W-1:0]    rptr;
  logic [IDX_W-1:0]    widx;
  logic [REP_W-1:0]    rep;
  logic [FILL_W-1:0]   fill;
  logic                en_q;
  logic                uf_q;
  logic [PW-1:0]       pix_q;

  logic                accept;
  logic                commit;
  logic                line_end;
  logic                last_rep;
  logic                release_line;
  logic                starve;
  logic                visible;
  logic                border;
  logic [IDX_W-1:0]    rd_idx;

  // Handshake and line-event decode
  always_comb begin
    o_pixel_ready = (fill < FILL_MAX);
    accept        = i_pixel_valid && o_pixel_ready;
    commit        = accept && (widx == IDX_LAST);
    line_end      = en_q && (i_vga_x == VIS_X);
    last_rep      = (rep == REP_LAST);
    release_line  = line_end && last_rep && (fill >= FILL_TWO);
    starve        = line_end && last_rep && (fill < FILL_TWO);
    visible       = en_q && (i_vga_x < VIS_X);
    rd_idx        = IDX_W'(i_vga_x >> SCALE_X_LOG2);
  end

`ifdef VIDEO_LINE_SCALER_BORDER_EN
  assign border = en_q && !visible && (i_vga_x < PIXEL_BITWIDTH'(VGA_ACTIVE_WIDTH));
`else
  logic unused_border_cfg;
  assign unused_border_cfg = (VGA_ACTIVE_WIDTH != 0) ^ (BORDER_RGB != '0);
  assign border = 1'b0;
`endif

  // Line buffer RAM write port (contents survive reset)
  always_ff @(posedge i_clk) begin
    if (accept) begin
      line_mem[wptr][widx] <= i_pixel_rgb;
    end
  end

  // Write side: pixel index and buffer pointer
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      widx <= '0;
      wptr <= '0;
    end else if (accept) begin
      if (commit) begin
        widx <= '0;
        wptr <= (wptr == PTR_LAST) ? '0 : wptr + 1'b1;
      end else begin
        widx <= widx + 1'b1;
      end
    end
  end

  // Read side: repeat counter, read pointer and sticky underflow
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rep  <= '0;
      rptr <= '0;
      uf_q <= 1'b0;
    end else if (line_end) begin
      if (!last_rep) begin
        rep <= rep + 1'b1;
      end else if (release_line) begin
        rep  <= '0;
        rptr <= (rptr == PTR_LAST) ? '0 : rptr + 1'b1;
      end else if (starve) begin
        uf_q <= 1'b1;
      end
    end
  end

  // Fill count: a commit and a release on the same edge cancel out
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      fill <= '0;
    end else if (commit && !release_line) begin
      fill <= fill + 1'b1;
    end else if (release_line && !commit) begin
      fill <= fill - 1'b1;
    end
  end

  // VGA release latches on the first committed line
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      en_q <= 1'b0;
    end else if (commit) begin
      en_q <= 1'b1;
    end
  end

  // Registered pixel output, one cycle after i_vga_x
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      pix_q <= '0;
    end else if (visible) begin
      pix_q <= line_mem[rptr][rd_idx];
    end else if (border) begin
      pix_q <= BORDER_RGB;
    end else begin
      pix_q <= '0;
    end
  end

  assign o_vga_enable     = en_q;
  assign o_underflow      = uf_q;
  assign o_lines_buffered = fill;
  assign o_vga_red        = pix_q[RGB_BITWIDTH-1:0];
  assign o_vga_green      = pix_q[2*RGB_BITWIDTH-1:RGB_BITWIDTH];
  assign o_vga_blue       = pix_q[3*RGB_BITWIDTH-1:2*RGB_BITWIDTH];

endmodule

// File: tb/tb_video_line_scaler.sv
// Self-checking bench for video_line_scaler with a queue-based line model.
module tb_video_line_scaler;

  localparam int SW  = 4;
  localparam int NL  = 3;
  localparam int SX  = 1;
  localparam int SY  = 2;
  localparam int ACT = 12;
  localparam int VIS = SW << SX;
  localparam logic [23:0] BORDER = 24'h102030;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_pixel_valid = 1'b0;
  logic [23:0] i_pixel_rgb = '0;
  logic [10:0] i_vga_x = '0;
  logic        o_pixel_ready;
  logic        o_vga_enable;
  logic [7:0]  o_vga_red;
  logic [7:0]  o_vga_green;
  logic [7:0]  o_vga_blue;
  logic        o_underflow;
  logic [1:0]  o_lines_buffered;

  always #5 i_clk = ~i_clk;

  video_line_scaler #(
    .PIXEL_BITWIDTH   (11),
    .RGB_BITWIDTH     (8),
    .SRC_WIDTH        (SW),
    .NUM_LINES        (NL),
    .SCALE_X_LOG2     (SX),
    .SCALE_Y          (SY),
    .VGA_ACTIVE_WIDTH (ACT),
    .BORDER_RGB       (BORDER)
  ) dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_pixel_valid    (i_pixel_valid),
    .i_pixel_rgb      (i_pixel_rgb),
    .o_pixel_ready    (o_pixel_ready),
    .o_vga_enable     (o_vga_enable),
    .i_vga_x          (i_vga_x),
    .o_vga_red        (o_vga_red),
    .o_vga_green      (o_vga_green),
    .o_vga_blue       (o_vga_blue),
    .o_underflow      (o_underflow),
    .o_lines_buffered (o_lines_buffered)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: complete lines as a flat pixel queue, plus the partial line.
  logic [23:0] lines_q[$];
  logic [23:0] part_q[$];
  int          m_rep;
  bit          m_en;
  bit          m_uf;
  logic [23:0] m_rgb;

  function automatic int m_lines();
    return lines_q.size() / SW;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    lines_q.delete();
    part_q.delete();
    m_rep = 0;
    m_en  = 1'b0;
    m_uf  = 1'b0;
    m_rgb = '0;
  endtask

  task automatic model_step(input bit v, input logic [23:0] d, input int x);
    int          n;
    bit          acc;
    logic [23:0] nrgb;
    n    = m_lines();
    acc  = v && (n < NL);
    nrgb = '0;
    if (m_en && x < VIS) nrgb = lines_q[x >> SX];
`ifdef VIDEO_LINE_SCALER_BORDER_EN
    else if (m_en && x < ACT) nrgb = BORDER;
`endif
    m_rgb = nrgb;
    if (m_en && x == VIS) begin
      if (m_rep < SY - 1) m_rep++;
      else if (n >= 2) begin
        for (int k = 0; k < SW; k++) void'(lines_q.pop_front());
        m_rep = 0;
      end else m_uf = 1'b1;
    end
    if (acc) begin
      part_q.push_back(d);
      if (part_q.size() == SW) begin
        foreach (part_q[k]) lines_q.push_back(part_q[k]);
        part_q.delete();
        m_en = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    check("enable",    32'(o_vga_enable),     32'(m_en));
    check("underflow", 32'(o_underflow),      32'(m_uf));
    check("lines",     32'(o_lines_buffered), 32'(m_lines()));
    check("rgb",       32'({o_vga_blue, o_vga_green, o_vga_red}), 32'(m_rgb));
  endtask

  // One clock: drive after negedge, check ready, clock, check registered outputs.
  task automatic cycle(input bit v, input logic [23:0] d, input int x, output bit acc);
    i_pixel_valid = v;
    i_pixel_rgb   = d;
    i_vga_x       = 11'(x);
    #1;
    check("ready", 32'(o_pixel_ready), 32'(m_lines() < NL));
    acc = v && o_pixel_ready;
    @(posedge i_clk);
    model_step(v, d, x);
    #1;
    check_outputs();
    @(negedge i_clk);
  endtask

  task automatic cyc(input bit v, input logic [23:0] d, input int x);
    bit a;
    cycle(v, d, x, a);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
  task automatic do_reset();
    i_reset       = 1'b1;
    i_pixel_valid = 1'b0;
    #1;
    model_reset();
    check_outputs();
    check("ready_rst", 32'(o_pixel_ready), 32'd1);
    @(posedge i_clk);
    @(negedge i_clk);
    i_reset = 1'b0;
  endtask

  task automatic push_line(input logic [23:0] base);
    for (int i = 0; i < SW; i++) cyc(1'b1, base + 24'(i), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    bit a;
    int n_acc;
    int le_pct;
    int v_pct;
    int x;
    model_reset();
    @(negedge i_clk);
    do_reset();

    // First line with value = index; release and 1-cycle read latency.
    for (int i = 0; i < SW; i++) begin
      cyc(1'b1, 24'(i), 0);
      check("en_during_line", 32'(o_vga_enable), 32'(i == SW - 1));
    end
    check("lines_first", 32'(o_lines_buffered), 32'd1);
    cyc(1'b0, '0, 6);
    check("red_x6", 32'(o_vga_red), 32'd3);

    // Backpressure: ready drops after NL*SW pixels; held pixel taken after release.
    do_reset();
    n_acc = 0;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 24'h0a0000 + 24'(i), 0, a);
      n_acc += int'(a);
    end
    check("acc_before_full", 32'(n_acc), 32'(NL * SW));
    check("lines_full", 32'(o_lines_buffered), 32'd3);
    cycle(1'b1, 24'h0b0b0b, VIS, a);
    check("held_first_le", 32'(a), 32'd0);
    cycle(1'b1, 24'h0b0b0b, VIS, a);
    check("held_release", 32'(a), 32'd0);
    cycle(1'b1, 24'h0b0b0b, 0, a);
    check("held_accepted", 32'(a), 32'd1);

    // Vertical repeat: only the second line end releases.
    do_reset();
    push_line(24'h100000);
    push_line(24'h200000);
    cyc(1'b0, '0, VIS);
    check("ly_first", 32'(o_lines_buffered), 32'd2);
    cyc(1'b0, '0, VIS);
    check("ly_second", 32'(o_lines_buffered), 32'd1);
    cyc(1'b0, '0, 1);
    check("ly_line_b", 32'({o_vga_blue, o_vga_green, o_vga_red}), 32'h200000);

    // Underflow with one line; sticky after a new line arrives.
    do_reset();
    push_line(24'h300000);
    cyc(1'b0, '0, VIS);
    cyc(1'b0, '0, VIS);
    check("uf_set", 32'(o_underflow), 32'd1);
    cyc(1'b0, '0, 2);
    check("uf_repeat_a", 32'({o_vga_blue, o_vga_green, o_vga_red}), 32'h300001);
    push_line(24'h400000);
    check("uf_sticky", 32'(o_underflow), 32'd1);

    // Commit and release on the same edge.
    do_reset();
    push_line(24'h500000);
    push_line(24'h600000);
    cyc(1'b0, '0, VIS);
    for (int i = 0; i < SW - 1; i++) cyc(1'b1, 24'h700000 + 24'(i), 0);
    cyc(1'b1, 24'h7000ff, VIS);
    check("same_edge_lines", 32'(o_lines_buffered), 32'd2);

    // Reset mid-line discards the partial line.
    cyc(1'b1, 24'h800000, 0);
    cyc(1'b1, 24'h800001, 0);
    do_reset();
    for (int i = 0; i < SW - 1; i++) cyc(1'b1, 24'h900000 + 24'(i), 0);
    check("en_after_partial", 32'(o_vga_enable), 32'd0);
    cyc(1'b1, 24'h900003, 0);
    check("en_after_full", 32'(o_vga_enable), 32'd1);

    // Border region between VIS and the active width.
    cyc(1'b0, '0, VIS + 1);
`ifdef VIDEO_LINE_SCALER_BORDER_EN
    check("border_rgb", 32'({o_vga_blue, o_vga_green, o_vga_red}), 32'h102030);
`else
    check("border_rgb", 32'({o_vga_blue, o_vga_green, o_vga_red}), 32'h0);
`endif

    // Randomized traffic, alternating between starving and flooding phases.
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      le_pct = ((k / 400) % 2 == 1) ? 45 : 10;
      v_pct  = ((k / 400) % 2 == 1) ? 40 : 85;
      x = ($urandom_range(0, 99) < le_pct) ? VIS : int'($urandom_range(0, 13));
      cyc($urandom_range(0, 99) < v_pct, 24'($urandom), x);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/video_line_scaler.md
Name: video_line_scaler

Overview:
- Parametrised line-buffer ring between the NES pixel FIFO and the VGA timing generator.
- Accepts source lines of SRC_WIDTH pixels into NUM_LINES line buffers.
- Replays each line to VGA with integer horizontal (2^SCALE_X_LOG2) and vertical (SCALE_Y) replication.
- Adds backpressure to the FIFO, a registered pixel output and a sticky underflow flag.

Parameters:
- PIXEL_BITWIDTH, 11, width of i_vga_x.
- RGB_BITWIDTH, 8, bits per colour channel; pixel word is 3*RGB_BITWIDTH, {blue,green,red} MSB to LSB.
- SRC_WIDTH, 256, source pixels per line; must be at least 2.
- NUM_LINES, 3, line buffers in the ring; must be at least 2.
- SCALE_X_LOG2, 1, horizontal replication is 2^SCALE_X_LOG2.
- SCALE_Y, 2, times each line is displayed; must be at least 1.
- VGA_ACTIVE_WIDTH, 640, VGA active pixels per line; used only by the optional feature.
- BORDER_RGB, 0, border colour word; used only by the optional feature.

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_pixel_valid  in  1  FIFO pixel valid.
- i_pixel_rgb  in  3*RGB_BITWIDTH  FIFO pixel data.
- o_pixel_ready  out  1  pixel accepted this cycle when high together with i_pixel_valid.
- o_vga_enable  out  1  releases VGA timing once the first line is buffered.
- i_vga_x  in  PIXEL_BITWIDTH  x of the VGA pixel to be shown next cycle.
- o_vga_red / o_vga_green / o_vga_blue  out  RGB_BITWIDTH each  registered pixel channels.
- o_underflow  out  1  sticky: a line end arrived with no next line ready.
- o_lines_buffered  out  clog2(NUM_LINES+1)  count of full lines held, including the line being displayed.

Behaviour:
- Reset (asynchronous, active-high): write pointer, read pointer, write index, repeat count and fill count go to 0. o_vga_enable=0, o_underflow=0, RGB outputs=0. Buffer RAM contents are not cleared.
- o_pixel_ready is combinational: 1 when fill < NUM_LINES.
- Write: on i_pixel_valid && o_pixel_ready, store the pixel at buffer[wptr][widx] and increment widx.
- Line commit: when the accepted pixel has widx == SRC_WIDTH-1, in the same edge:
  - widx becomes 0;
  - wptr advances (NUM_LINES-1 wraps to 0);
  - fill increments;
  - o_vga_enable is set to 1 and stays 1 until reset.
- Visible region: VIS = SRC_WIDTH << SCALE_X_LOG2. A pixel is visible when o_vga_enable && i_vga_x < VIS.
- Read latency is 1 cycle. When visible, the output register loads buffer[rptr][i_vga_x >> SCALE_X_LOG2]; otherwise it loads 0.
- Line-end event: o_vga_enable && i_vga_x == VIS, evaluated every cycle with that value.
  - If rep < SCALE_Y-1: rep increments and the same line is shown again.
  - Else if fill >= 2: rptr advances (with wrap), rep=0, fill decrements.
  - Else (underflow): rptr and rep are held, the current line is re-displayed, and o_underflow is set.
- Commit and release in the same cycle: fill is unchanged.
- Fill never exceeds NUM_LINES. Pixels presented while ready=0 are not consumed and widx does not move.
- Reset mid-line: a partial write line is discarded and display restarts only after a full new line is committed.

Optional Feature:
- Macro: VIDEO_LINE_SCALER_BORDER_EN.
- Defined: when o_vga_enable && VIS <= i_vga_x < VGA_ACTIVE_WIDTH, the output register loads BORDER_RGB instead of 0.
- Not defined: every non-visible pixel outputs 0, and VGA_ACTIVE_WIDTH and BORDER_RGB are unused.

Test Plan:
- Reset, then stream 256 pixels with value = index: o_vga_enable goes to 1 on the edge accepting pixel 255, o_lines_buffered=1. i_vga_x=6 gives red=3 one cycle later.
- SRC_WIDTH=4, NUM_LINES=3, valid held high with no line ends: ready drops after 12 accepted pixels, lines_buffered=3. The 13th pixel is held until the first line release.
- SCALE_Y=2 with lines A and B buffered: the first line end leaves rptr at A and the second moves to B; lines_buffered goes 2 to 1 only on the second.
- Only one line buffered, two line ends: line A is repeated, o_underflow=1 and stays 1 after a new line arrives.
- Commit and line release on the same edge: lines_buffered unchanged. Assert i_reset mid-line: all outputs 0 at once and enable returns only after 256 further pixels.
- With VIDEO_LINE_SCALER_BORDER_EN and BORDER_RGB=24'h102030, i_vga_x=600: blue=8'h10, green=8'h20, red=8'h30. Without the macro all three are 0.
